// File: rtl/full_adder.sv
// One-bit full adder with a combinational result path (safe to ripple-chain
// Cout-to-Cin) and a single registered stage that counts accepted operations.
module full_adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        A,
  input  logic        B,
  input  logic        Cin,
  input  logic        in_valid,
  output logic        sum,
  output logic        Cout,
  output logic        p,
  output logic        g,
  output logic        sum_q,
  output logic        cout_q,
  output logic        out_valid,
  output logic [15:0] op_count
);

  logic        sum_p1;
  logic        cout_p1;
  logic        vld_p1;
  logic [15:0] cnt_p1;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic gen, input logic prop, input logic c);
    return gen | (prop & c);
  endfunction

  // Stage p0: combinational; reset and in_valid deliberately do not reach here.
  assign p    = A ^ B;
  assign g    = A & B;
  assign sum  = fa_sum(A, B, Cin);
  assign Cout = fa_carry(g, p, Cin);

  // Stage p1: registered result, qualifier and operation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_p1  <= 1'b0;
      cout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      cnt_p1  <= 16'h0000;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum;
        cout_p1 <= Cout;
        cnt_p1  <= cnt_p1 + 16'd1;
      end
    end
  end

  assign sum_q     = sum_p1;
  assign cout_q    = cout_p1;
  assign out_valid = vld_p1;
  assign op_count  = cnt_p1;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: truth table, 64-bit ripple chain,
// registered path, hold, reset priority and counter wrap.
module tb_full_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        A, B, Cin, in_valid;
  logic        sum, Cout, p, g, sum_q, cout_q, out_valid;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Cin(Cin), .in_valid(in_valid),
    .sum(sum), .Cout(Cout), .p(p), .g(g),
    .sum_q(sum_q), .cout_q(cout_q), .out_valid(out_valid), .op_count(op_count)
  );

  // 64-bit ripple chain built from the same cell
  logic [63:0] ra, rb, rs, rp, rg, rsq, rcq, rov;
  logic        rcin;
  logic [64:0] rc;
  logic [15:0] rcnt [64];
  assign rc[0] = rcin;

  for (genvar i = 0; i < 64; i++) begin : g_chain
    full_adder u_fa (
      .clk(clk), .reset(reset), .A(ra[i]), .B(rb[i]), .Cin(rc[i]), .in_valid(1'b0),
      .sum(rs[i]), .Cout(rc[i+1]), .p(rp[i]), .g(rg[i]),
      .sum_q(rsq[i]), .cout_q(rcq[i]), .out_valid(rov[i]), .op_count(rcnt[i])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic v, input logic r);
    @(negedge clk);
    A = a; B = b; Cin = c; in_valid = v; reset = r;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sum, exp_cout, exp_p, exp_g;

  initial begin
    A = 0; B = 0; Cin = 0; in_valid = 0; reset = 1;
    ra = '0; rb = '0; rcin = 0;

    // reset state
    edge_settle();
    check("rst_sum_q", sum_q, 0);
    check("rst_cout_q", cout_q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);

    // exhaustive combinational table, indexed by {A,B,Cin}, checked while in reset
    exp_sum  = 8'b1001_0110;
    exp_cout = 8'b1110_1000;
    exp_p    = 8'b0011_1100;
    exp_g    = 8'b1100_0000;
    for (int i = 0; i < 8; i++) begin
      drive(i[2], i[1], i[0], i[0], 1'b1);
      #1;
      check($sformatf("sum_%0d", i), sum, exp_sum[i]);
      check($sformatf("cout_%0d", i), Cout, exp_cout[i]);
      check($sformatf("p_%0d", i), p, exp_p[i]);
      check($sformatf("g_%0d", i), g, exp_g[i]);
    end

    // registered path: 1+1+0 -> sum_q=0, cout_q=1
    drive(1, 1, 0, 1, 0);
    edge_settle();
    check("reg_sum_q", sum_q, 0);
    check("reg_cout_q", cout_q, 1);
    check("reg_out_valid", out_valid, 1);
    check("reg_op_count", op_count, 1);

    // hold with in_valid low and changed inputs
    drive(1, 0, 0, 0, 0);
    edge_settle();
    check("hold_sum_q", sum_q, 0);
    check("hold_cout_q", cout_q, 1);
    check("hold_out_valid", out_valid, 0);
    check("hold_op_count", op_count, 1);
    check("hold_sum_comb", sum, 1);
    check("hold_cout_comb", Cout, 0);

    // second accepted op: 0+0+1 -> sum_q=1, cout_q=0
    drive(0, 0, 1, 1, 0);
    edge_settle();
    check("op2_sum_q", sum_q, 1);
    check("op2_cout_q", cout_q, 0);
    check("op2_op_count", op_count, 2);

    // reset beats in_valid; combinational path keeps tracking inputs
    drive(1, 1, 1, 1, 1);
    edge_settle();
    check("mid_rst_sum_q", sum_q, 0);
    check("mid_rst_cout_q", cout_q, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_sum", sum, 1);
    check("mid_rst_cout", Cout, 1);

    // ripple chain
    ra = 64'd4; rb = 64'd2; rcin = 0;
    #1;
    check("ripple_4p2", rs, 64'd6);
    check("ripple_4p2_cout", rc[64], 0);
    ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'd1;
    #1;
    check("ripple_max_p1", rs, 64'd0);
    check("ripple_max_p1_cout", rc[64], 1);
    ra = 64'h8000_0000_1234_5678; rb = 64'h8000_0000_0000_0001; rcin = 1;
    #1;
    check("ripple_mix", rs, 64'h0000_0000_1234_567A);
    check("ripple_mix_cout", rc[64], 1);

    // counter wrap after 65536 accepted operations
    drive(0, 1, 0, 1, 0);
    repeat (65535) @(posedge clk);
    #1;
    check("wrap_ffff", op_count, 16'hFFFF);
    edge_settle();
    check("wrap_zero", op_count, 16'h0000);
    check("wrap_sum_q", sum_q, 1);
    check("wrap_out_valid", out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
Parameters:
REQ-001 The block SHALL have no parameters; all widths are fixed as stated below.

Ports:
REQ-002 clk  input  1  single clock; all sequential elements SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 A  input  1  addend bit.
REQ-005 B  input  1  addend bit.
REQ-006 Cin  input  1  carry-in bit.
REQ-007 in_valid  input  1  qualifies A/B/Cin for the registered stage.
REQ-008 sum  output  1  combinational sum bit.
REQ-009 Cout  output  1  combinational carry-out bit.
REQ-010 p  output  1  combinational propagate, A XOR B.
REQ-011 g  output  1  combinational generate, A AND B.
REQ-012 sum_q  output  1  registered sum.
REQ-013 cout_q  output  1  registered carry-out.
REQ-014 out_valid  output  1  registered qualifier for sum_q/cout_q.
REQ-015 op_count  output  16  count of accepted operations.

Function
REQ-016 sum SHALL equal A XOR B XOR Cin at all times, with zero cycles of latency and no dependence on clk or reset.
REQ-017 Cout SHALL equal (A AND B) OR (Cin AND (A XOR B)) at all times, with zero cycles of latency.
REQ-018 The combinational path SHALL be free of latches and loops, so 64 instances can be chained Cout-to-Cin into a ripple adder.
REQ-019 For every input combination, {Cout,sum} SHALL equal the 2-bit unsigned value A+B+Cin.
REQ-020 p and g SHALL be purely combinational, and Cout SHALL equal g OR (p AND Cin).
REQ-021 On a rising clk with reset low and in_valid high, sum_q and cout_q SHALL load the current sum and Cout, and out_valid SHALL become 1 (latency 1 cycle).
REQ-022 On a rising clk with reset low and in_valid low, sum_q and cout_q SHALL hold their values and out_valid SHALL become 0.
REQ-023 On each rising clk with reset low and in_valid high, op_count SHALL increment by 1, wrapping from 16'hFFFF to 16'h0000 with no flag.
REQ-024 in_valid SHALL have no effect on the combinational outputs sum, Cout, p and g.

Reset
REQ-025 On a rising clk with reset high, sum_q, cout_q and out_valid SHALL become 0 and op_count SHALL become 16'h0000, regardless of in_valid.
REQ-026 Reset SHALL take priority over a simultaneous in_valid, and that cycle SHALL not be counted.
REQ-027 Reset SHALL NOT affect sum, Cout, p or g, which SHALL remain combinational functions of A, B and Cin throughout reset.
REQ-028 Registered outputs SHALL be undefined until the first reset edge; no power-on value is guaranteed.

Verification
REQ-029 Exhaustive combinational check: all 8 {A,B,Cin} values -> {Cout,sum} = A+B+Cin (e.g. 1,1,1 -> Cout=1, sum=1; 1,0,0 -> Cout=0, sum=1), p = A^B, g = A&B.
REQ-030 Ripple check: chain 64 instances; A=4, B=2, carry-in 0 -> result 6; A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> result 0 with final Cout=1.
REQ-031 Registered path: reset for 1 cycle, then apply A=1, B=1, Cin=0 with in_valid=1 -> after the next edge sum_q=0, cout_q=1, out_valid=1, op_count=1.
REQ-032 Hold behaviour: drop in_valid and change the inputs -> sum_q and cout_q are unchanged, out_valid=0, and op_count is unchanged.
REQ-033 Reset mid-operation: assert reset with in_valid=1 -> after the edge all registered outputs are 0, op_count=0, and sum/Cout still track the inputs.
REQ-034 Wrap: apply 65536 accepted operations after reset -> op_count returns to 16'h0000.
